// File: rtl/ah_demux_route_stage.sv
// ah_demux_route_stage
// Registered routing front-end for the 11-way AH demux. Each packet's destination
// is taken from its SOP beat and carried alongside every beat of that packet.
// Beats leave through a two-entry (main + skid) buffer so that ing_ready can be a
// plain register. Packets with an illegal destination, and orphan beats seen
// outside a packet, are accepted and discarded, and each one is counted.
module ah_demux_route_stage #(
    parameter int DATA_W  = 258,
    parameter int NUM_EGR = 11,
    parameter int SEL_W   = 4,
    parameter int SEL_LSB = 0,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] ing_data,
    input  logic              ing_valid,
    output logic              ing_ready,
    output logic [DATA_W-1:0] egr_data,
    output logic              egr_valid,
    input  logic              egr_ready,
    output logic [SEL_W-1:0]  egr_select,
    output logic              drop_pulse,
    output logic [CNT_W-1:0]  drop_count
);

    localparam logic [1:0]  ST_IDLE   = 2'd0;
    localparam logic [1:0]  ST_PASS   = 2'd1;
    localparam logic [1:0]  ST_DROP   = 2'd2;
    localparam logic [31:0] NUM_EGR_U = 32'(NUM_EGR);

    // Packet tracking
    logic [1:0]        r_state;
    logic [SEL_W-1:0]  r_cur_sel;

    // Output buffer: main entry drives the egress, skid entry absorbs one extra beat
    logic              r_main_valid;
    logic [DATA_W-1:0] r_main_data;
    logic [SEL_W-1:0]  r_main_sel;
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_data;
    logic [SEL_W-1:0]  r_skid_sel;
    logic              r_ing_ready;
    logic              r_drop_pulse;
    logic [CNT_W-1:0]  r_drop_count;

    logic              w_sop;
    logic              w_eop;
    logic [SEL_W-1:0]  w_dest;
    logic              w_legal;
    logic              w_ing_fire;
    logic              w_main_free;

    logic              w_write;
    logic              w_drop;
    logic [SEL_W-1:0]  w_sel;
    logic [1:0]        w_state_next;
    logic [SEL_W-1:0]  w_cur_sel_next;

    logic              w_main_valid_next;
    logic [DATA_W-1:0] w_main_data_next;
    logic [SEL_W-1:0]  w_main_sel_next;
    logic              w_skid_valid_next;
    logic [DATA_W-1:0] w_skid_data_next;
    logic [SEL_W-1:0]  w_skid_sel_next;

    assign w_sop       = ing_data[DATA_W-1];
    assign w_eop       = ing_data[DATA_W-2];
    assign w_dest      = ing_data[SEL_LSB +: SEL_W];
    assign w_legal     = (32'(w_dest) < NUM_EGR_U);
    assign w_ing_fire  = ing_valid & r_ing_ready;
    // Main can take a new beat if it is empty or its current beat leaves this cycle
    assign w_main_free = ~r_main_valid | egr_ready;

    // Classify each accepted beat: forward it (with which select) or discard it
    always_comb begin
        w_write        = 1'b0;
        w_drop         = 1'b0;
        w_sel          = r_cur_sel;
        w_state_next   = r_state;
        w_cur_sel_next = r_cur_sel;
        if (w_ing_fire) begin
            if (w_sop) begin
                // Any SOP starts a fresh packet, even in the middle of another one
                if (w_legal) begin
                    w_write        = 1'b1;
                    w_sel          = w_dest;
                    w_cur_sel_next = w_dest;
                    w_state_next   = w_eop ? ST_IDLE : ST_PASS;
                end else begin
                    w_drop       = 1'b1;
                    w_state_next = w_eop ? ST_IDLE : ST_DROP;
                end
            end else begin
                case (r_state)
                    ST_PASS: begin
                        w_write = 1'b1;
                        if (w_eop) begin
                            w_state_next = ST_IDLE;
                        end
                    end
                    ST_DROP: begin
                        if (w_eop) begin
                            w_state_next = ST_IDLE;
                        end
                    end
                    default: begin
                        // Continuation beat with no open packet
                        w_drop       = 1'b1;
                        w_state_next = ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Buffer next state; the skid entry always drains into main ahead of new beats
    always_comb begin
        w_main_valid_next = r_main_valid;
        w_main_data_next  = r_main_data;
        w_main_sel_next   = r_main_sel;
        w_skid_valid_next = r_skid_valid;
        w_skid_data_next  = r_skid_data;
        w_skid_sel_next   = r_skid_sel;
        if (r_skid_valid) begin
            // ing_ready is low here, so no new beat can arrive this cycle
            if (w_main_free) begin
                w_main_valid_next = 1'b1;
                w_main_data_next  = r_skid_data;
                w_main_sel_next   = r_skid_sel;
                w_skid_valid_next = 1'b0;
            end
        end else if (w_write) begin
            if (w_main_free) begin
                w_main_valid_next = 1'b1;
                w_main_data_next  = ing_data;
                w_main_sel_next   = w_sel;
            end else begin
                w_skid_valid_next = 1'b1;
                w_skid_data_next  = ing_data;
                w_skid_sel_next   = w_sel;
            end
        end else if (w_main_free) begin
            w_main_valid_next = 1'b0;
        end
    end

    // Packet state and the select latched from the current packet's SOP
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cur_sel <= '0;
        end else begin
            r_state   <= w_state_next;
            r_cur_sel <= w_cur_sel_next;
        end
    end

    // Buffer registers; ready is registered from the skid occupancy it will have
    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_main_sel   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_sel   <= '0;
            r_ing_ready  <= 1'b0;
        end else begin
            r_main_valid <= w_main_valid_next;
            r_main_data  <= w_main_data_next;
            r_main_sel   <= w_main_sel_next;
            r_skid_valid <= w_skid_valid_next;
            r_skid_data  <= w_skid_data_next;
            r_skid_sel   <= w_skid_sel_next;
            r_ing_ready  <= ~w_skid_valid_next;
        end
    end

    // Drop reporting: one pulse per rejected packet, saturating counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_pulse <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_drop_pulse <= w_drop;
            if (w_drop && (r_drop_count != {CNT_W{1'b1}})) begin
                r_drop_count <= r_drop_count + 1'b1;
            end
        end
    end

    assign ing_ready  = r_ing_ready;
    assign egr_valid  = r_main_valid;
    assign egr_data   = r_main_data;
    assign egr_select = r_main_sel;
    assign drop_pulse = r_drop_pulse;
    assign drop_count = r_drop_count;

endmodule

// File: tb/tb_ah_demux_route_stage.sv
// Scoreboard bench for ah_demux_route_stage: the driver pushes the expected
// {data, select} of every beat that should be forwarded; a monitor pops and
// compares whenever the egress handshakes. A second instance with a 4-bit drop
// counter shares the stimulus so counter saturation is reached quickly.
module tb_ah_demux_route_stage;

    localparam int DW = 258;
    localparam int SW = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] ing_data = '0;
    logic          ing_valid = 1'b0;
    logic          ing_ready;
    logic [DW-1:0] egr_data;
    logic          egr_valid;
    logic          egr_ready = 1'b1;
    logic [SW-1:0] egr_select;
    logic          drop_pulse;
    logic [CW-1:0] drop_count;

    logic          sat_ing_ready;
    logic [DW-1:0] sat_egr_data;
    logic          sat_egr_valid;
    logic [SW-1:0] sat_egr_select;
    logic          sat_drop_pulse;
    logic [3:0]    sat_drop_count;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [SW-1:0] s;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    int            checks = 0;
    int            errors = 0;
    bit            tog_en = 1'b0;

    logic          prev_v = 1'b0;
    logic          prev_r = 1'b0;
    logic          prev_rst = 1'b1;
    logic [DW-1:0] prev_d = '0;
    logic [SW-1:0] prev_s = '0;

    ah_demux_route_stage u_dut (
        .clk        (clk),
        .rst        (rst),
        .ing_data   (ing_data),
        .ing_valid  (ing_valid),
        .ing_ready  (ing_ready),
        .egr_data   (egr_data),
        .egr_valid  (egr_valid),
        .egr_ready  (egr_ready),
        .egr_select (egr_select),
        .drop_pulse (drop_pulse),
        .drop_count (drop_count)
    );

    ah_demux_route_stage #(.CNT_W(4)) u_sat (
        .clk        (clk),
        .rst        (rst),
        .ing_data   (ing_data),
        .ing_valid  (ing_valid),
        .ing_ready  (sat_ing_ready),
        .egr_data   (sat_egr_data),
        .egr_valid  (sat_egr_valid),
        .egr_ready  (egr_ready),
        .egr_select (sat_egr_select),
        .drop_pulse (sat_drop_pulse),
        .drop_count (sat_drop_count)
    );

    always #5 clk = ~clk;

    // egress backpressure pattern 1,0,1,0... while enabled
    always @(posedge clk) begin
        if (tog_en) begin
            #1 egr_ready = ~egr_ready;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [DW-1:0] mk(input bit sop, input bit eop,
                                         input logic [SW-1:0] dest, input logic [15:0] tag);
        logic [DW-1:0] d;
        d           = '0;
        d[DW-1]     = sop;
        d[DW-2]     = eop;
        d[SW-1:0]   = dest;
        d[DW-3 -: 16] = tag;
        return d;
    endfunction

    // Present one beat, hold it until accepted, record the expected egress beat
    task automatic send(input logic [DW-1:0] d, input bit fwd, input logic [SW-1:0] sel);
        bit ok;
        ok        = 1'b0;
        ing_data  = d;
        ing_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ing_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            if (fwd) exp_q.push_back('{d: d, s: sel});
        end else begin
            checks++;
            errors++;
            $display("FAIL send_timeout tag=%0h actual=not_accepted required=accepted", d[DW-3 -: 16]);
        end
        @(posedge clk);
        #1 ing_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !egr_valid) break;
        end
        chk(name, 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every egress handshake, and hold stability under backpressure
    always @(negedge clk) begin
        if (!rst && !prev_rst && prev_v && !prev_r) begin
            checks++;
            if (!(egr_valid && egr_data == prev_d && egr_select == prev_s)) begin
                errors++;
                $display("FAIL hold_stable actual=v%0b sel%0h tag%0h required=v1 sel%0h tag%0h",
                         egr_valid, egr_select, egr_data[DW-3 -: 16], prev_s, prev_d[DW-3 -: 16]);
            end
        end
        if (!rst && egr_valid && egr_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat actual=tag%0h sel%0h required=none",
                         egr_data[DW-3 -: 16], egr_select);
            end else begin
                mon_e = exp_q.pop_front();
                if (egr_data !== mon_e.d || egr_select !== mon_e.s) begin
                    errors++;
                    $display("FAIL egr_beat actual=data%0h sel%0h required=data%0h sel%0h",
                             egr_data, egr_select, mon_e.d, mon_e.s);
                end else begin
                    $display("beat tag=%0h sel=%0d ok", egr_data[DW-3 -: 16], egr_select);
                end
            end
        end
        prev_v   = egr_valid;
        prev_r   = egr_ready;
        prev_rst = rst;
        prev_d   = egr_data;
        prev_s   = egr_select;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ing_ready", 32'(ing_ready), 32'd0);
        chk("rst_egr_valid", 32'(egr_valid), 32'd0);
        chk("rst_drop_count", 32'(drop_count), 32'd0);
        chk("rst_drop_pulse", 32'(drop_pulse), 32'd0);
        chk("rst_egr_select", 32'(egr_select), 32'd0);
        chk("rst_egr_data_zero", 32'(egr_data == '0), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_ing_ready", 32'(ing_ready), 32'd1);

        // 1: single-beat packet, one-cycle latency
        send(mk(1, 1, 4'd5, 16'h0001), 1'b1, 4'd5);
        chk("t1_latency_valid", 32'(egr_valid), 32'd1);
        chk("t1_select", 32'(egr_select), 32'd5);
        wait_drain("t1_drain");

        // 2: four-beat packet under alternating backpressure
        tog_en = 1'b1;
        send(mk(1, 0, 4'd10, 16'h0021), 1'b1, 4'd10);
        send(mk(0, 0, 4'd0,  16'h0022), 1'b1, 4'd10);
        send(mk(0, 0, 4'd3,  16'h0023), 1'b1, 4'd10);
        send(mk(0, 1, 4'd0,  16'h0024), 1'b1, 4'd10);
        tog_en = 1'b0;
        @(posedge clk);
        #2 egr_ready = 1'b1;
        @(posedge clk);
        #1;
        wait_drain("t2_drain");

        // 3: back-to-back packets with egress stalled for three cycles
        egr_ready = 1'b0;
        send(mk(1, 0, 4'd3, 16'h0031), 1'b1, 4'd3);
        send(mk(0, 0, 4'd0, 16'h0032), 1'b1, 4'd3);
        chk("t3_ing_ready_low", 32'(ing_ready), 32'd0);
        fork
            begin
                @(posedge clk);
                #1 egr_ready = 1'b1;
            end
            begin
                send(mk(0, 1, 4'd0, 16'h0033), 1'b1, 4'd3);
                send(mk(1, 0, 4'd7, 16'h0034), 1'b1, 4'd7);
                send(mk(0, 1, 4'd0, 16'h0035), 1'b1, 4'd7);
            end
        join
        wait_drain("t3_drain");

        // 4: illegal destination dropped as a whole packet, next packet passes
        send(mk(1, 0, 4'd11, 16'h0041), 1'b0, 4'd0);
        chk("t4_drop_pulse", 32'(drop_pulse), 32'd1);
        send(mk(0, 0, 4'd0, 16'h0042), 1'b0, 4'd0);
        chk("t4_drop_pulse_once", 32'(drop_pulse), 32'd0);
        send(mk(0, 1, 4'd0, 16'h0043), 1'b0, 4'd0);
        send(mk(1, 1, 4'd0, 16'h0044), 1'b1, 4'd0);
        chk("t4_drop_count", 32'(drop_count), 32'd1);
        wait_drain("t4_drain");

        // 5: orphan beat, then saturation of the narrow counter
        do_reset();
        send(mk(0, 1, 4'd3, 16'h0051), 1'b0, 4'd0);
        chk("t5_orphan_pulse", 32'(drop_pulse), 32'd1);
        chk("t5_orphan_count", 32'(drop_count), 32'd1);
        for (int i = 0; i < 16; i++) begin
            send(mk(0, 0, 4'd0, 16'(16'h0060 + i)), 1'b0, 4'd0);
        end
        chk("t5_count_17", 32'(drop_count), 32'd17);
        chk("t5_sat_count", 32'(sat_drop_count), 32'hF);
        wait_drain("t5_nothing_forwarded");

        // 6: reset with both buffer entries full
        egr_ready = 1'b0;
        send(mk(1, 0, 4'd4, 16'h0061), 1'b0, 4'd0);
        send(mk(0, 0, 4'd0, 16'h0062), 1'b0, 4'd0);
        chk("t6_full_ing_ready", 32'(ing_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_rst_egr_valid", 32'(egr_valid), 32'd0);
        chk("t6_rst_drop_count", 32'(drop_count), 32'd0);
        chk("t6_rst_ing_ready", 32'(ing_ready), 32'd0);
        rst = 1'b0;
        egr_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_post_rst_ing_ready", 32'(ing_ready), 32'd1);
        send(mk(1, 1, 4'd2, 16'h0063), 1'b1, 4'd2);
        chk("t6_new_valid", 32'(egr_valid), 32'd1);
        chk("t6_new_select", 32'(egr_select), 32'd2);
        wait_drain("t6_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
